// File: rtl/gemm_pkg.sv
// Shared geometry and state encoding for the GEMM output writeback stage.
// Tile geometry lives here so every block agrees on how a tile is laid out.
package gemm_pkg;

   localparam int OutDataWidth = 32;
   localparam int RowPar       = 4;
   localparam int ColPar       = 16;
   localparam int WordElems    = 4;

   localparam int TileWidth    = RowPar * ColPar * OutDataWidth;
   localparam int WordWidth    = WordElems * OutDataWidth;
   localparam int NumWords     = (RowPar * ColPar) / WordElems;
   localparam int CntWidth     = (NumWords > 1) ? $clog2(NumWords) : 1;

   typedef enum logic {
      WB_IDLE,
      WB_WRITE
   } wb_state_e;

endpackage

// File: rtl/gemm_output_writeback.sv
// Serialises one accepted RowPar x ColPar accumulator tile into row-major
// SRAM C words, one word per unstalled cycle, allowing back-to-back tiles.
// Optional build macro: GEMM_WB_WRITE_COUNT_EN adds a saturating write counter.
module gemm_output_writeback
   import gemm_pkg::*;
#(
   parameter int AddrWidth = 12
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 tile_valid_i,
   output logic                 tile_ready_o,
   input  logic [TileWidth-1:0] tile_data_i,
   input  logic [AddrWidth-1:0] tile_base_addr_i,
   input  logic                 tile_last_i,
   input  logic                 sram_c_stall_i,
   output logic [AddrWidth-1:0] sram_c_addr_o,
   output logic [WordWidth-1:0] sram_c_wdata_o,
   output logic                 sram_c_we_o,
   output logic                 busy_o,
   output logic                 done_o
`ifdef GEMM_WB_WRITE_COUNT_EN
   ,
   output logic [31:0]          wr_count_o
`endif
);

   localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumWords - 1);

   wb_state_e               state_q;
   wb_state_e               state_d;
   logic [TileWidth-1:0]    tile_q;
   logic [AddrWidth-1:0]    base_q;
   logic                    last_q;
   logic [CntWidth-1:0]     cnt_q;
   logic                    done_q;
   logic                    writing;
   logic                    final_word;
   logic                    accept;

   assign writing    = (state_q == WB_WRITE);
   assign final_word = writing && (cnt_q == LastCnt) && !sram_c_stall_i;
   assign accept     = tile_valid_i && tile_ready_o;

   // Handshake readiness, write port drive and status flags from registered state.
   always_comb begin
      tile_ready_o   = (state_q == WB_IDLE) || final_word;
      sram_c_we_o    = 1'b0;
      sram_c_addr_o  = '0;
      sram_c_wdata_o = '0;
      if (writing) begin
         sram_c_we_o    = !sram_c_stall_i;
         sram_c_addr_o  = base_q + AddrWidth'(cnt_q);
         sram_c_wdata_o = tile_q[cnt_q*WordWidth +: WordWidth];
      end
      busy_o = writing;
      done_o = done_q;
   end

   // Next-state: a new tile may follow the final word directly without an idle gap.
   always_comb begin
      state_d = state_q;
      case (state_q)
         WB_IDLE: begin
            if (accept) state_d = WB_WRITE;
         end
         WB_WRITE: begin
            if (final_word) state_d = accept ? WB_WRITE : WB_IDLE;
         end
         default: state_d = WB_IDLE;
      endcase
   end

   // State register, tile capture on handshake and word counter advance.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= WB_IDLE;
         tile_q  <= '0;
         base_q  <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            tile_q <= tile_data_i;
            base_q <= tile_base_addr_i;
            last_q <= tile_last_i;
            cnt_q  <= '0;
         end else if (writing && !sram_c_stall_i) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Done pulses the cycle after the final word of a tile marked last.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) done_q <= 1'b0;
      else         done_q <= final_word && last_q;
   end

`ifdef GEMM_WB_WRITE_COUNT_EN
   logic [31:0] wr_count_q;

   // Saturating count of issued writes; only reset clears it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                   wr_count_q <= '0;
      else if (sram_c_we_o && (wr_count_q != '1))    wr_count_q <= wr_count_q + 32'd1;
   end

   assign wr_count_o = wr_count_q;
`endif

endmodule

// File: doc/gemm_output_writeback.md
Name: gemm_output_writeback

Overview:
- Downstream stage of gemm_accelerator_top. Accepts one finished RowPar x ColPar result tile of 32-bit accumulators in a single valid/ready handshake.
- Serialises the tile into narrower row-major words for the output SRAM C.
- Replaces the current single-address 2048-bit C write, so SRAM C can use a realistic word width.

Parameters:
- OutDataWidth, 32, width of one accumulator element
- RowPar, 4, tile rows
- ColPar, 16, tile columns
- WordElems, 4, elements per SRAM C word; must divide RowPar*ColPar
- AddrWidth, 12, SRAM C address width
- TileWidth, RowPar*ColPar*OutDataWidth, derived; 2048 by default
- WordWidth, WordElems*OutDataWidth, derived; 128 by default
- NumWords, RowPar*ColPar/WordElems, derived; 16 by default

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- tile_valid_i  in  1  tile offered
- tile_ready_o  out  1  tile can be accepted
- tile_data_i  in  TileWidth  element (r,c) at bits [(r*ColPar+c)*OutDataWidth +: OutDataWidth]
- tile_base_addr_i  in  AddrWidth  SRAM C word address of tile word 0
- tile_last_i  in  1  tile is the final tile of the GEMM
- sram_c_stall_i  in  1  SRAM C cannot take a write this cycle
- sram_c_addr_o  out  AddrWidth  write address
- sram_c_wdata_o  out  WordWidth  write data
- sram_c_we_o  out  1  write enable
- busy_o  out  1  a tile is being written
- done_o  out  1  one-cycle pulse after the final word of a last tile is written

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; tile_q, base_q, last_q, cnt_q = 0.
- Outputs under reset: tile_ready_o=1, sram_c_we_o=0, sram_c_addr_o=0, sram_c_wdata_o=0, busy_o=0, done_o=0.
- Reset mid-tile aborts the tile; no further writes are issued.
- States are IDLE and WRITE.
- Accept: handshake when tile_valid_i && tile_ready_o at rising edge T. Capture tile_data_i, tile_base_addr_i and tile_last_i; set cnt_q=0; enter WRITE.
- tile_ready_o = (state==IDLE) || (state==WRITE && cnt_q==NumWords-1 && !sram_c_stall_i). This allows back-to-back tiles.
- In WRITE, outputs are combinational from registers:
  - sram_c_we_o = !sram_c_stall_i
  - sram_c_addr_o = base_q + cnt_q, modulo 2^AddrWidth; wraps silently
  - sram_c_wdata_o = tile_q[cnt_q*WordWidth +: WordWidth]; element j of word k is tile element k*WordElems+j
- Stall: while sram_c_stall_i=1, we=0, and addr, data and cnt_q hold. Stall in IDLE has no effect.
- Each unstalled WRITE cycle increments cnt_q.
- On the unstalled cycle with cnt_q==NumWords-1:
  - If a new tile handshakes the same cycle, stay in WRITE, reload registers, cnt_q=0.
  - Otherwise go to IDLE.
- Latency: first write in cycle T+1. With no stalls, the last write is in cycle T+NumWords (T+16 default).
- done_o: registered pulse, high for one cycle in the cycle after the final word write of a tile with last_q=1.
- busy_o = (state==WRITE).
- In IDLE: we=0, addr=0, wdata=0.
- Writes carry no sign or width conversion; element bits pass through unchanged.

Optional Feature:
- Macro GEMM_WB_WRITE_COUNT_EN.
- When defined: adds output port wr_count_o [31:0], counting every cycle with sram_c_we_o=1. Reset to 0 by rst_ni, saturates at 2^32-1, never cleared by done_o.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package gemm_pkg holds:
  - the OutDataWidth, RowPar, ColPar and WordElems defaults
  - the derived TileWidth, WordWidth and NumWords localparams
  - a wb_state_e typedef {WB_IDLE, WB_WRITE}
- No sub-module is needed; the word mux is an indexed part-select inside the block.

Test Plan:
- Single tile, element e = e+1, base 0x010, last=0, no stall -> 16 writes at addr 0x010..0x01F in cycles T+1..T+16; word 0 = {4,3,2,1}; done_o stays 0.
- Same tile with last=1 -> done_o high exactly at T+17 for one cycle; busy_o falls at T+17.
- Stall held high in cycles T+3..T+5 -> we=0 there; addr holds 0x012; 16 writes complete by T+19 in order with no duplicates.
- Back-to-back: second tile valid continuously, base 0x020 -> ready=1 in T+16; writes to 0x020 start at T+17 with no gap cycle.
- Base 0xFFE -> addresses 0xFFE, 0xFFF, 0x000 ... 0x00D.
- Reset asserted at T+8 -> we=0 and ready=1 immediately; no writes after release until a new handshake; with GEMM_WB_WRITE_COUNT_EN, wr_count_o=0.
